// File: rtl/processor_pipe_if.sv
// Instruction-in / result-out handshake bundle for processor_pipe.
// master = sequencer/sink side, slave = the core.
interface processor_pipe_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned ILEN = 32;
  localparam int unsigned AW   = 5;

  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instruction;
  logic            result_valid;
  logic            result_ready;
  logic [XLEN-1:0] result;
  logic [AW-1:0]   result_rd;

  modport master (
    output instr_valid, instruction, result_ready,
    input  instr_ready, result_valid, result, result_rd
  );

  modport slave (
    input  instr_valid, instruction, result_ready,
    output instr_ready, result_valid, result, result_rd
  );
endinterface

// File: rtl/processor_pipe.sv
// Two-stage (decode/execute -> result) ALU core with an NREGS x XLEN register file.
// Optional condition flags (flag_z/n/c/v) are built when PROC_FLAGS_EN is defined.
module processor_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  processor_pipe_if.slave bus,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
`ifdef PROC_FLAGS_EN
  ,
  output logic            flag_z,
  output logic            flag_n,
  output logic            flag_c,
  output logic            flag_v
`endif
);

  localparam int unsigned OPW   = 6;
  localparam int unsigned IMMW  = 16;
  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned AWP   = AW + 1;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_ADDI = 6'd6
  } op_e;

  // rs2 lives in imm[15:11]; the two fields overlap by design
  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [IMMW-1:0] imm;
  } instr_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [XLEN-1:0] regs [DEPTH];
  instr_t          s1;
  logic            s1_valid;
  logic            res_valid;
  logic [XLEN-1:0] res;
  logic [AW-1:0]   res_rd;

  // ------------------------------------------------------------------
  // Handshake / control
  // ------------------------------------------------------------------
  logic            s1_advance;
  logic            accept;
  logic            is_alu;
  op_e             op;
  logic [AW-1:0]   rs2;

  function automatic logic in_range(input logic [AW-1:0] idx);
    return {1'b0, idx} < AWP'(NREGS);
  endfunction

  assign s1_advance      = s1_valid & (~res_valid | bus.result_ready);
  assign bus.instr_ready = ~reset & (~s1_valid | s1_advance);
  assign accept          = bus.instr_valid & bus.instr_ready;

  assign op     = op_e'(s1.opcode);
  assign is_alu = (s1.opcode <= OPW'(OP_ADDI));
  assign rs2    = s1.imm[IMMW-1 -: AW];

  assign bus.result_valid = res_valid;
  assign bus.result       = res;
  assign bus.result_rd    = res_rd;

  // ------------------------------------------------------------------
  // Operand read: r0 and out-of-range indices read as zero
  // ------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((s1.rs1 != '0) && in_range(s1.rs1)) rs1_val = regs[s1.rs1];
    if ((rs2 != '0) && in_range(rs2))       rs2_val = regs[rs2];
  end

  always_comb begin
    dbg_data = '0;
    if ((dbg_addr != '0) && in_range(dbg_addr)) dbg_data = regs[dbg_addr];
  end

  assign imm_ext = XLEN'($signed(s1.imm));

  // ------------------------------------------------------------------
  // ALU (all arithmetic wraps modulo 2^XLEN)
  // ------------------------------------------------------------------
  logic [XLEN-1:0] alu;

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rs1_val + rs2_val;
      OP_SUB:  alu = rs1_val - rs2_val;
      OP_AND:  alu = rs1_val & rs2_val;
      OP_OR:   alu = rs1_val | rs2_val;
      OP_XOR:  alu = rs1_val ^ rs2_val;
      OP_SLL:  alu = rs1_val << rs2_val[SHW-1:0];
      OP_ADDI: alu = rs1_val + imm_ext;
      default: alu = '0;
    endcase
  end

`ifdef PROC_FLAGS_EN
  // ------------------------------------------------------------------
  // Condition flags: carry derived from wrap-around, overflow from sign rules
  // ------------------------------------------------------------------
  localparam int unsigned FW = 4;

  logic [XLEN-1:0] opb;
  logic            fz;
  logic            fn;
  logic            fc;
  logic            fv;
  logic [FW-1:0]   flags_q;

  always_comb begin
    fz  = (alu == '0);
    fn  = alu[XLEN-1];
    fc  = 1'b0;
    fv  = 1'b0;
    opb = (op == OP_ADDI) ? imm_ext : rs2_val;
    case (op)
      OP_ADD, OP_ADDI: begin
        fc = (alu < rs1_val);
        fv = (rs1_val[XLEN-1] == opb[XLEN-1]) && (alu[XLEN-1] != rs1_val[XLEN-1]);
      end
      OP_SUB: begin
        fc = (rs1_val >= rs2_val);
        fv = (rs1_val[XLEN-1] != rs2_val[XLEN-1]) && (alu[XLEN-1] != rs1_val[XLEN-1]);
      end
      default: begin
        fc = 1'b0;
        fv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (s1_advance && is_alu) begin
      flags_q <= {fz, fn, fc, fv};
    end
  end

  assign flag_z = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
`endif

  // ------------------------------------------------------------------
  // S1 capture: refills on the same edge it drains
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1       <= instr_t'(bus.instruction);
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // S2 result register; NOPs drain S1 without producing a beat
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res       <= '0;
      res_rd    <= '0;
    end else if (s1_advance) begin
      res_valid <= is_alu;
      if (is_alu) begin
        res    <= alu;
        res_rd <= s1.rd;
      end
    end else if (bus.result_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Register file write-back shares the S2 load edge; r0/out-of-range dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (s1_advance && is_alu && (s1.rd != '0) && in_range(s1.rd)) begin
      regs[s1.rd] <= alu;
    end
  end

endmodule
